// File: rtl/tawas_pkg.sv
// tawas_pkg: shared types and constants for the Tawas fetch front end.
//   thread_state_e : per-thread run state (IDLE, READY, BUSY)
//   tag_t          : {thread, pc} tag layout for the default configuration
//                    (32 threads, 24-bit PC). Parametrised modules declare
//                    a local tag struct of the same shape.
//   HALF_BIT       : index of the half-select bit in a default-width PC register
//   half_bit()     : half-select bit index for an arbitrary PC width
package tawas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    BUSY  = 2'd2
  } thread_state_e;

  localparam int THREADS_DEF = 32;
  localparam int PC_W_DEF    = 24;
  localparam int TW_DEF      = $clog2(THREADS_DEF);

  // PC registers are PC_W+1 bits: the word address sits below the
  // half-select bit, which occupies the top position.
  localparam int HALF_BIT = PC_W_DEF;

  typedef struct packed {
    logic [TW_DEF-1:0] thread;
    logic [PC_W_DEF:0] pc;
  } tag_t;

  function automatic int half_bit(input int pc_w);
    return pc_w;
  endfunction

endpackage

// File: rtl/tawas_tag_fifo.sv
// tawas_tag_fifo: synchronous FIFO holding fetch tags in request order.
//   clk, rst : clock, asynchronous active-high reset (pointers and count)
//   push/din : write a tag (ignored when full unless a pop happens too)
//   pop/dout : read-ahead head entry; pop advances (ignored when empty)
//   full, empty, count : occupancy status, count in 0..DEPTH
module tawas_tag_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  // A push while full is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tawas_fetch_rr.sv
// tawas_fetch_rr: multithreaded instruction-fetch front end with fair
// round-robin thread selection.
//   clk, rst                  : clock, asynchronous active-high reset
//   ireq/iaddr/iready         : fetch request to instruction memory
//   ivalid/idata              : in-order responses from memory
//   instr_vld/instr/...       : fetched word to decode with {thread, {half, PC}}
//   pc_upd_*                  : decode re-arms (next PC) or halts a BUSY thread
//   start_*                   : launch an IDLE thread at a given PC
//   thread_run                : per-thread "not IDLE" flags
//   err                       : sticky; orphan response or bad pc_upd target
module tawas_fetch_rr
  import tawas_pkg::*;
#(
  parameter  int                 THREADS   = 32,
  parameter  int                 PC_W      = 24,
  parameter  int                 DEPTH     = 4,
  parameter  logic [THREADS-1:0] RESET_RUN = '1,
  localparam int                 TW        = $clog2(THREADS)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ireq,
  output logic [PC_W-1:0]    iaddr,
  input  logic               iready,
  input  logic               ivalid,
  input  logic [31:0]        idata,
  output logic               instr_vld,
  output logic [31:0]        instr,
  output logic [TW-1:0]      instr_thread,
  output logic [PC_W:0]      instr_pc,
  input  logic               pc_upd_en,
  input  logic [TW-1:0]      pc_upd_thread,
  input  logic [PC_W:0]      pc_upd_pc,
  input  logic               pc_upd_halt,
  input  logic               start_en,
  input  logic [TW-1:0]      start_thread,
  input  logic [PC_W-1:0]    start_pc,
  output logic [THREADS-1:0] thread_run,
  output logic               err
);

  localparam int HB = half_bit(PC_W);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TW-1:0] thread;
    logic [PC_W:0] pc;
  } ftag_t;

  localparam int TAG_W = $bits(ftag_t);

  thread_state_e      st_q [THREADS];
  logic [PC_W:0]      pc_q [THREADS];
  logic [TW-1:0]      last_grant;
  logic [THREADS-1:0] ready;

  logic               grant_vld;
  logic [TW-1:0]      grant_idx;
  logic [PC_W:0]      grant_pc;
  logic               sel_fire;

  ftag_t              req_tag;
  ftag_t              tag_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        occ;
  logic               push;
  logic               pop;
  logic               upd_bad;

  always_comb begin
    ready      = '0;
    thread_run = '0;
    for (int t = 0; t < THREADS; t++) begin
      ready[t]      = (st_q[t] == READY);
      thread_run[t] = (st_q[t] != IDLE);
    end
  end

  // Round robin: the "hi" search only sees threads strictly above the last
  // grant; when none qualifies, the plain lowest-index search wraps around.
  always_comb begin
    logic          found_hi;
    logic          found_lo;
    logic [TW-1:0] idx_hi;
    logic [TW-1:0] idx_lo;
    logic [PC_W:0] pc_hi;
    logic [PC_W:0] pc_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    pc_hi    = '0;
    pc_lo    = '0;
    for (int t = 0; t < THREADS; t++) begin
      if (ready[t]) begin
        if (!found_lo) begin
          found_lo = 1'b1;
          idx_lo   = TW'(t);
          pc_lo    = pc_q[t];
        end
        if (!found_hi && (t > int'(last_grant))) begin
          found_hi = 1'b1;
          idx_hi   = TW'(t);
          pc_hi    = pc_q[t];
        end
      end
    end
    grant_vld = found_lo;
    grant_idx = found_hi ? idx_hi : idx_lo;
    grant_pc  = found_hi ? pc_hi  : pc_lo;
  end

  // Occupancy counts the request register as already queued, so a new
  // selection can never push the tag FIFO past DEPTH entries.
  assign occ      = {1'b0, fifo_count} + (CW + 1)'(ireq);
  assign sel_fire = grant_vld && (!ireq || iready) && !fifo_full &&
                    (occ < (CW + 1)'(DEPTH));

  assign push = ireq && iready;
  assign pop  = ivalid && !fifo_empty;

  always_comb begin
    logic upd_hit;
    upd_hit = 1'b0;
    for (int t = 0; t < THREADS; t++) begin
      if ((pc_upd_thread == TW'(t)) && (st_q[t] == BUSY)) upd_hit = 1'b1;
    end
    upd_bad = pc_upd_en && !upd_hit;
  end

  // Per-thread state. Select only hits READY, pc_upd only acts on BUSY and
  // start only on IDLE, so at most one branch can apply to a thread.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < THREADS; t++) begin
        st_q[t] <= RESET_RUN[t] ? READY : IDLE;
        pc_q[t] <= (PC_W + 1)'(t);
      end
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        if (sel_fire && (grant_idx == TW'(t))) begin
          st_q[t] <= BUSY;
        end else if (pc_upd_en && (pc_upd_thread == TW'(t)) && (st_q[t] == BUSY)) begin
          st_q[t] <= pc_upd_halt ? IDLE : READY;
          if (!pc_upd_halt) pc_q[t] <= pc_upd_pc;
        end else if (start_en && (start_thread == TW'(t)) && (st_q[t] == IDLE)) begin
          st_q[t] <= READY;
          pc_q[t] <= {1'b0, start_pc};
        end
      end
    end
  end

  // Request register: loads on select, holds while stalled, drops once
  // accepted with nothing new behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ireq       <= 1'b0;
      iaddr      <= '0;
      req_tag    <= '0;
      last_grant <= TW'(THREADS - 1);
    end else if (sel_fire) begin
      ireq           <= 1'b1;
      iaddr          <= grant_pc[HB-1:0];
      req_tag.thread <= grant_idx;
      req_tag.pc     <= grant_pc;
      last_grant     <= grant_idx;
    end else if (iready) begin
      ireq <= 1'b0;
    end
  end

  tawas_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (req_tag),
    .pop   (pop),
    .dout  (tag_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_vld    <= 1'b0;
      instr        <= '0;
      instr_thread <= '0;
      instr_pc     <= '0;
      err          <= 1'b0;
    end else begin
      instr_vld <= pop;
      if (pop) begin
        instr        <= idata;
        instr_thread <= tag_head.thread;
        instr_pc     <= tag_head.pc;
      end
      if ((ivalid && fifo_empty) || upd_bad) err <= 1'b1;
    end
  end

endmodule

// File: doc/tawas_fetch_rr.md
# tawas_fetch_rr

Parametrised multithreaded instruction-fetch front end for the Tawas core. It keeps a PC and run state per hardware thread and picks a ready thread each cycle with fair round-robin, instead of fixed priority. It issues fetches to a variable-latency, stallable instruction memory and tracks in-flight fetches in an ordered tag queue. Fetched words go to the decode stage tagged with thread and PC. Decode returns each thread's next PC, or a halt, to re-arm it.

## Interface
- THREADS, 32: hardware thread count, 2..64; TW = clog2(THREADS)
- PC_W, 24: instruction word-address width
- DEPTH, 4: max outstanding fetches, power of 2, ≥2
- RESET_RUN, all ones (THREADS bits): threads READY after reset; others IDLE

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ireq  out  1  fetch request valid
- iaddr  out  PC_W  fetch word address
- iready  in  1  memory accepts request when ireq&&iready
- ivalid  in  1  response valid, in request order
- idata  in  32  response word
- instr_vld  out  1  fetched instruction valid to decode
- instr  out  32  instruction word
- instr_thread  out  TW  owning thread
- instr_pc  out  PC_W+1  {half-select, PC} of fetched word
- pc_upd_en  in  1  decode finished thread's instruction
- pc_upd_thread  in  TW  thread
- pc_upd_pc  in  PC_W+1  next {half, PC}
- pc_upd_halt  in  1  thread halts instead of re-arming
- start_en  in  1  launch an IDLE thread
- start_thread  in  TW  thread
- start_pc  in  PC_W  launch PC, half-select 0
- thread_run  out  THREADS  bit set when thread is not IDLE
- err  out  1  sticky: ivalid with empty tag queue, or pc_upd on non-BUSY thread

## Operation
- Per-thread state: IDLE, READY, BUSY. Per-thread PC register is PC_W+1 bits.
- Transitions:
  - IDLE→READY on start_en; PC set to {0,start_pc}.
  - READY→BUSY when the thread is selected.
  - BUSY→READY on pc_upd_en with halt=0; PC set to pc_upd_pc.
  - BUSY→IDLE on pc_upd_en with halt=1; PC is unchanged.
- start_en to a non-IDLE thread is ignored and does not set err.
- start_en and pc_upd_en never target the same thread in one cycle (they require different states).
- Select: among READY threads, grant the lowest index strictly above last_grant, wrapping; last_grant resets to THREADS-1, so thread 0 is granted first.
- Select fires only when the request register is free (!ireq || iready) and the tag queue will not overflow. Queue count + pending request must stay < DEPTH.
- Request register: on select, load ireq=1, iaddr=PC[PC_W-1:0], and tag {thread, PC}. Hold all values while ireq && !iready. Drop ireq after acceptance when nothing is selected.
- On acceptance, push the tag into the tag queue (DEPTH-entry FIFO).
- ivalid pops the queue and registers instr/instr_thread/instr_pc, with instr_vld=1 for one cycle.
- An ivalid with an empty queue sets err and is dropped.
- Push and pop in the same cycle leave the count unchanged. This is legal when full.
- Each thread has at most one instruction in flight, so there is no intra-thread reorder.

## Timing
- Reset values: ireq=0, iaddr=0, instr_vld=0, instr=0, instr_thread=0, instr_pc=0, err=0.
- Reset state: thread_run=RESET_RUN; PC[t]={0,t}; tag queue empty.
- Select in cycle n → ireq high in cycle n+1.
- Memory with zero wait (iready=1, ivalid one cycle after acceptance): select n, ireq n+1, ivalid n+2, instr_vld n+3.
- pc_upd_en at cycle m → thread eligible for select at m+1.
- Throughput: one request per cycle when ≥2 threads are READY and the queue is not full.
- A single thread issues one fetch per (memory latency + decode loop) cycles.
- rst mid-operation discards queued tags and any in-flight request. Responses arriving after reset deassert are counted as err.

## Structure
- tawas_pkg gains:
  - thread state enum {IDLE, READY, BUSY}
  - tag struct {thread, pc}
  - HALF_BIT index constant
- Sub-module tawas_tag_fifo: a parametrised sync FIFO, width = TW+PC_W+1, DEPTH entries, with full/empty/count.
- Round-robin arbiter stays inline; it is a mask-and-priority pair.

## Test plan
- Reset, THREADS=4, iready=1, 1-cycle memory, immediate pc_upd(pc+1) → iaddr sequence 0,1,2,3,1,2,3,4…; instr_thread rotates 0,1,2,3.
- iready low for 5 cycles with ireq=1 → iaddr/ireq stable; queue depth unchanged; no lost or duplicated tags after release.
- Memory latency 6, DEPTH=4, all threads READY → at most 4 accepted requests outstanding; 5th ireq waits until an ivalid.
- pc_upd_halt on thread 2 → thread_run[2]=0 and thread 2 never selected. start_en thread 2 pc=0x100 → next iaddr for thread 2 is 0x100.
- start_en on a READY thread → ignored, err stays 0. ivalid with empty queue → err=1, sticky until rst.
- Assert rst with 3 fetches outstanding → all outputs at reset values next cycle; resumes with thread 0 at iaddr 0.
